// File: rtl/abs_sample_collector.sv
// abs_sample_collector: 8-channel saturated-magnitude frame assembler.
// Define ABS_SAMPLE_COLLECTOR_OFFSET_BINARY_EN for offset-binary sample_data.
module abs_sample_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         enable,
    input  logic         sample_valid,
    input  logic [2:0]   sample_channel,
    input  logic [15:0]  sample_data,
    output logic [119:0] abs_sample_concat,
    output logic         frame_valid,
    output logic [15:0]  frame_count,
    output logic         err_duplicate,
    output logic         err_timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_ERROR   = 2'd2;

    localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]        state;
    logic              in_valid;
    logic [2:0]        in_ch;
    logic [15:0]       in_data;
    logic              s1_valid;
    logic [2:0]        s1_ch;
    logic [14:0]       s1_mag;
    logic [7:0][14:0]  staging;
    logic [7:0]        mask;
    logic [15:0]       timer;

    logic              commit;
    logic [7:0]        base_mask;
    logic [7:0]        wr_bit;
    logic              dup;
    logic              wr;
    logic              timed_out;
    logic [7:0]        mask_n;
    logic [15:0]       timer_n;

    function automatic logic [14:0] to_mag(input logic [15:0] d);
        logic [15:0] x;
        logic [15:0] neg;
`ifdef ABS_SAMPLE_COLLECTOR_OFFSET_BINARY_EN
        x = {~d[15], d[14:0]};
`else
        x = d;
`endif
        neg = 16'd0 - x;
        if (x == 16'h8000)
            return 15'h7fff;
        else if (x[15])
            return neg[14:0];
        else
            return x[14:0];
    endfunction

    // A commit clears the mask before the same-edge write is checked.
    always_comb begin
        commit    = (mask == 8'hff);
        base_mask = commit ? 8'h00 : mask;
        wr_bit    = 8'b1 << s1_ch;
        dup       = s1_valid && ((base_mask & wr_bit) != 8'h00);
        wr        = s1_valid && !dup;
        timed_out = !commit && (timer == TIMER_LIMIT);
        mask_n    = base_mask | (wr ? wr_bit : 8'h00);
        if (!commit && mask != 8'h00)
            timer_n = timer + 16'd1;
        else
            timer_n = wr ? 16'd1 : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= ST_IDLE;
            in_valid          <= 1'b0;
            in_ch             <= 3'd0;
            in_data           <= 16'd0;
            s1_valid          <= 1'b0;
            s1_ch             <= 3'd0;
            s1_mag            <= 15'd0;
            staging           <= '0;
            mask              <= 8'h00;
            timer             <= 16'd0;
            abs_sample_concat <= 120'd0;
            frame_valid       <= 1'b0;
            frame_count       <= 16'd0;
            err_duplicate     <= 1'b0;
            err_timeout       <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    in_valid <= 1'b0;
                    s1_valid <= 1'b0;
                    mask     <= 8'h00;
                    timer    <= 16'd0;
                    if (enable)
                        state <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (!enable) begin
                        state    <= ST_IDLE;
                        in_valid <= 1'b0;
                        s1_valid <= 1'b0;
                        mask     <= 8'h00;
                        timer    <= 16'd0;
                    end else if (dup || timed_out) begin
                        state         <= ST_ERROR;
                        err_duplicate <= err_duplicate | dup;
                        err_timeout   <= err_timeout | timed_out;
                    end else begin
                        in_valid <= sample_valid;
                        in_ch    <= sample_channel;
                        in_data  <= sample_data;
                        s1_valid <= in_valid;
                        s1_ch    <= in_ch;
                        s1_mag   <= to_mag(in_data);
                        mask     <= mask_n;
                        timer    <= timer_n;
                        if (wr)
                            staging[s1_ch] <= s1_mag;
                        if (commit) begin
                            abs_sample_concat <= staging;
                            frame_valid       <= 1'b1;
                            frame_count       <= frame_count + 16'd1;
                        end
                    end
                end
                ST_ERROR: begin
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
